// File: rtl/adc_access_arbiter.sv
// Round-robin arbiter that shares the board ADC between the auto-scan sequencer and host one-shot reads.
// Each conversion is sequenced as setup, one-cycle go pulse, then wait-for-valid with a timeout.
module adc_access_arbiter #(
    parameter int TIMEOUT_CYCLES = 65520,
    parameter int MAX_CHAN       = 16
) (
    input  logic       clk3p2M,
    input  logic       rst_n,
    input  logic       auto_req,
    input  logic [4:0] auto_chan,
    output logic       auto_ack,
    input  logic       host_req,
    input  logic [4:0] host_chan,
    output logic       host_ack,
    output logic [9:0] rd_data,
    output logic       rd_err,
    output logic       last_grant,
    output logic       busy,
    output logic [7:0] timeout_cnt,
    output logic       adc_go,
    output logic [3:0] adc_chan,
    output logic       adc_batt_sel,
    input  logic [9:0] adc_in,
    input  logic       adc_valid
);

    localparam int              CNT_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM_CNT  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]      MAX_CHAN_L = 5'(MAX_CHAN);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        GO,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             any_req;
    logic             grant_host;
    logic [4:0]       sel_chan;

    // On a tie the requester that did not own the previous conversion wins.
    always_comb begin
        any_req    = auto_req | host_req;
        grant_host = host_req & (~auto_req | ~last_grant);
        sel_chan   = grant_host ? host_chan : auto_chan;
    end

    always_ff @(posedge clk3p2M or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            auto_ack     <= 1'b0;
            host_ack     <= 1'b0;
            rd_data      <= '0;
            rd_err       <= 1'b0;
            last_grant   <= 1'b0;
            busy         <= 1'b0;
            timeout_cnt  <= '0;
            adc_go       <= 1'b0;
            adc_chan     <= '0;
            adc_batt_sel <= 1'b0;
        end else begin
            auto_ack <= 1'b0;
            host_ack <= 1'b0;
            adc_go   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last_grant <= grant_host;
                        busy       <= 1'b1;
                        // Illegal channels complete with an error without touching the ADC pins.
                        if (sel_chan > MAX_CHAN_L) begin
                            rd_data  <= '0;
                            rd_err   <= 1'b1;
                            auto_ack <= ~grant_host;
                            host_ack <= grant_host;
                            state    <= DONE;
                        end else begin
                            adc_chan     <= sel_chan[3:0];
                            adc_batt_sel <= sel_chan[4];
                            state        <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    adc_go <= 1'b1;
                    state  <= GO;
                end
                GO: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (adc_valid) begin
                        rd_data  <= adc_in;
                        rd_err   <= 1'b0;
                        auto_ack <= ~last_grant;
                        host_ack <= last_grant;
                        state    <= DONE;
                    end else if (wait_cnt == TERM_CNT) begin
                        rd_data  <= '0;
                        rd_err   <= 1'b1;
                        auto_ack <= ~last_grant;
                        host_ack <= last_grant;
                        if (timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_access_arbiter.sv
// Scoreboard bench for adc_access_arbiter: stimulus pushes expected completions, a monitor checks each ack.
// A small ADC model answers each adc_go after a programmable number of cycles.
module tb_adc_access_arbiter;

    localparam int TIMEOUT_CYCLES = 8;

    logic       clk3p2M;
    logic       rst_n;
    logic       auto_req;
    logic [4:0] auto_chan;
    logic       auto_ack;
    logic       host_req;
    logic [4:0] host_chan;
    logic       host_ack;
    logic [9:0] rd_data;
    logic       rd_err;
    logic       last_grant;
    logic       busy;
    logic [7:0] timeout_cnt;
    logic       adc_go;
    logic [3:0] adc_chan;
    logic       adc_batt_sel;
    logic [9:0] adc_in;
    logic       adc_valid;

    adc_access_arbiter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_CHAN      (16)
    ) dut (
        .clk3p2M     (clk3p2M),
        .rst_n       (rst_n),
        .auto_req    (auto_req),
        .auto_chan   (auto_chan),
        .auto_ack    (auto_ack),
        .host_req    (host_req),
        .host_chan   (host_chan),
        .host_ack    (host_ack),
        .rd_data     (rd_data),
        .rd_err      (rd_err),
        .last_grant  (last_grant),
        .busy        (busy),
        .timeout_cnt (timeout_cnt),
        .adc_go      (adc_go),
        .adc_chan    (adc_chan),
        .adc_batt_sel(adc_batt_sel),
        .adc_in      (adc_in),
        .adc_valid   (adc_valid)
    );

    typedef struct {
        logic       owner;
        logic [9:0] data;
        logic       err;
        logic [4:0] chan;
        int         lat;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int fails  = 0;
    int cycle  = 0;
    int go_seen = 0;
    int go_cycle = 0;
    logic prev_go = 1'b0;

    logic       resp_en    = 1'b1;
    int         resp_delay = 3;
    logic [9:0] resp_data  = '0;
    int         stray_req  = 0;

    initial begin
        clk3p2M = 1'b0;
        forever #10 clk3p2M = ~clk3p2M;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual,
                     expected, expected);
        end
    endtask

    // ADC model: answers a go pulse resp_delay cycles later, or emits a stray strobe on request.
    initial begin : adc_model
        int d;
        int stray_seen;
        stray_seen = 0;
        adc_valid  = 1'b0;
        adc_in     = '0;
        forever begin
            @(negedge clk3p2M);
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                adc_in     = 10'h1C7;
                adc_valid  = 1'b1;
                @(negedge clk3p2M);
                adc_valid = 1'b0;
            end else if (adc_go && resp_en && rst_n) begin
                d = resp_delay;
                repeat (d) @(posedge clk3p2M);
                #1;
                adc_in    = resp_data;
                adc_valid = 1'b1;
                @(posedge clk3p2M);
                #1;
                adc_valid = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every ack and checks result, owner, channel and latency.
    always @(negedge clk3p2M) begin
        exp_t e;
        if (!rst_n) begin
            go_seen = 0;
            prev_go = 1'b0;
        end else begin
            cycle++;
            if (adc_go) begin
                checkOutput("go_single_cycle", int'(prev_go), 0);
                checkOutput("go_while_busy", int'(busy), 1);
                go_seen++;
                go_cycle = cycle;
            end
            prev_go = adc_go;
            if (auto_ack || host_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_ack: auto_ack=%0b host_ack=%0b with empty scoreboard",
                             auto_ack, host_ack);
                end else begin
                    e = sb.pop_front();
                    checkOutput("ack_owner", int'({host_ack, auto_ack}), e.owner ? 2 : 1);
                    checkOutput("rd_data", int'(rd_data), int'(e.data));
                    checkOutput("rd_err", int'(rd_err), int'(e.err));
                    checkOutput("last_grant", int'(last_grant), int'(e.owner));
                    if (e.lat == 0) begin
                        checkOutput("no_go_for_illegal", go_seen, 0);
                    end else begin
                        checkOutput("go_count", go_seen, 1);
                        checkOutput("go_to_ack_latency", cycle - go_cycle, e.lat);
                        checkOutput("adc_mux", int'({adc_batt_sel, adc_chan}), int'(e.chan));
                    end
                end
                go_seen = 0;
            end
        end
    end

    task automatic doReset();
        rst_n    = 1'b0;
        auto_req = 1'b0;
        host_req = 1'b0;
        repeat (3) @(negedge clk3p2M);
        rst_n = 1'b1;
        repeat (2) @(negedge clk3p2M);
    endtask

    task automatic applyStimulus(input logic who, input logic [4:0] chan, input logic [9:0] exp_data,
                                 input logic exp_err, input int lat, output int waited);
        exp_t e;
        logic got;
        e.owner = who;
        e.data  = exp_data;
        e.err   = exp_err;
        e.chan  = chan;
        e.lat   = lat;
        sb.push_back(e);
        got    = 1'b0;
        waited = 0;
        @(posedge clk3p2M);
        #1;
        if (who) begin
            host_chan = chan;
            host_req  = 1'b1;
        end else begin
            auto_chan = chan;
            auto_req  = 1'b1;
        end
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk3p2M);
            waited++;
            if ((who && host_ack) || (!who && auto_ack)) begin
                got = 1'b1;
            end
        end
        auto_req = 1'b0;
        host_req = 1'b0;
        if (!got) begin
            checks++;
            fails++;
            $display("[TB] FAIL ack_timeout: no ack within 300 cycles for chan %0d", chan);
        end
        repeat (2) @(negedge clk3p2M);
    endtask

    initial begin : stimulus
        int waited;
        int acks;
        rst_n     = 1'b0;
        auto_req  = 1'b0;
        host_req  = 1'b0;
        auto_chan = '0;
        host_chan = '0;
        #1;
        checkOutput("reset_outputs", int'({auto_ack, host_ack, rd_data, rd_err, last_grant, busy,
                                           timeout_cnt, adc_go, adc_chan, adc_batt_sel}), 0);
        doReset();
        checkOutput("idle_busy", int'(busy), 0);

        $display("[TB] single auto read, chan 5");
        resp_en = 1'b1; resp_delay = 3; resp_data = 10'h2A5;
        applyStimulus(1'b0, 5'd5, 10'h2A5, 1'b0, 4, waited);
        checkOutput("auto_grant_to_ack", waited, 7);

        $display("[TB] host battery read, chan 16");
        resp_data = 10'h3FF;
        applyStimulus(1'b1, 5'd16, 10'h3FF, 1'b0, 4, waited);

        $display("[TB] illegal channel 20");
        applyStimulus(1'b0, 5'd20, 10'h000, 1'b1, 0, waited);
        checkOutput("illegal_grant_to_ack", waited, 2);
        checkOutput("rd_held_after_ack", int'({rd_err, rd_data}), 1024);

        $display("[TB] timeout, ADC silent");
        resp_en = 1'b0;
        applyStimulus(1'b0, 5'd2, 10'h000, 1'b1, 9, waited);
        checkOutput("timeout_grant_to_ack", waited, 12);
        checkOutput("timeout_cnt_1", int'(timeout_cnt), 1);

        $display("[TB] valid on terminal wait cycle");
        resp_en = 1'b1; resp_delay = 8; resp_data = 10'h0C3;
        applyStimulus(1'b1, 5'd9, 10'h0C3, 1'b0, 9, waited);
        checkOutput("timeout_cnt_still_1", int'(timeout_cnt), 1);

        $display("[TB] contention host 7 / auto 3");
        doReset();
        resp_delay = 1; resp_data = 10'h155;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.owner = (i % 2 == 0);
            e.data  = 10'h155;
            e.err   = 1'b0;
            e.chan  = (i % 2 == 0) ? 5'd7 : 5'd3;
            e.lat   = 2;
            sb.push_back(e);
        end
        @(posedge clk3p2M);
        #1;
        auto_chan = 5'd3;
        host_chan = 5'd7;
        auto_req  = 1'b1;
        host_req  = 1'b1;
        acks = 0;
        for (int i = 0; i < 400 && acks < 4; i++) begin
            @(negedge clk3p2M);
            if (auto_ack || host_ack) acks++;
        end
        auto_req = 1'b0;
        host_req = 1'b0;
        checkOutput("contention_ack_count", acks, 4);
        repeat (3) @(negedge clk3p2M);

        $display("[TB] reset during wait, then stray valid");
        resp_en = 1'b0;
        @(posedge clk3p2M);
        #1;
        auto_chan = 5'd4;
        auto_req  = 1'b1;
        repeat (5) @(posedge clk3p2M);
        #3;
        checkOutput("busy_before_reset", int'(busy), 1);
        rst_n    = 1'b0;
        auto_req = 1'b0;
        #1;
        checkOutput("mid_reset_outputs", int'({auto_ack, host_ack, rd_data, rd_err, last_grant, busy,
                                               timeout_cnt, adc_go, adc_chan, adc_batt_sel}), 0);
        @(negedge clk3p2M);
        rst_n = 1'b1;
        stray_req++;
        repeat (10) @(negedge clk3p2M);
        checkOutput("after_stray_outputs", int'({auto_ack, host_ack, rd_data, rd_err, last_grant, busy,
                                                 timeout_cnt, adc_go, adc_chan, adc_batt_sel}), 0);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/adc_access_arbiter.md
Name: adc_access_arbiter

Overview:
- Shares the single board ADC (adc_go / adc_chan / adc_batt_sel / adc_in / adc_valid) between two requesters: the continuous auto-scan sequencer and host one-shot reads issued from SPI registers.
- Arbitrates round-robin between the two requesters and sequences each conversion as setup → go pulse → wait-for-valid with timeout.
- Returns the 10-bit result to the winning requester with a one-cycle ack.
- Sits between the SPI register file / scan logic and the ADC interface pins.

Parameters:
- TIMEOUT_CYCLES, 65520, WAIT-state cycles before a conversion is abandoned (≥2).
- MAX_CHAN, 16, highest legal logical channel. Channel 16 is the battery path.

Ports:
- clk3p2M  in  1  3.2 MHz system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- auto_req  in  1  auto-scan request level; held until auto_ack.
- auto_chan  in  5  auto-scan logical channel, 0..16.
- auto_ack  out  1  one-cycle completion pulse to auto-scan.
- host_req  in  1  host request level; held until host_ack.
- host_chan  in  5  host logical channel, 0..16.
- host_ack  out  1  one-cycle completion pulse to host.
- rd_data  out  10  result of last completed conversion; valid with ack and held until the next ack.
- rd_err  out  1  qualifies the ack: 1 = timeout or illegal channel. Held with rd_data.
- last_grant  out  1  owner of the current/last conversion: 0 = auto, 1 = host.
- busy  out  1  high in every state except IDLE.
- timeout_cnt  out  8  saturating count of timeouts since reset.
- adc_go  out  1  conversion start pulse to ADC.
- adc_chan  out  4  physical mux channel: chan[3:0].
- adc_batt_sel  out  1  battery mux select: chan[4].
- adc_in  in  10  ADC result.
- adc_valid  in  1  ADC result strobe.

Behaviour:
- Reset: every output is 0; the FSM is in IDLE and the timeout counter is 0. Reset is legal mid-conversion; a later stray adc_valid in IDLE is ignored.
- FSM states: IDLE, SETUP, GO, WAIT, DONE.
- IDLE, no request pending: stay in IDLE.
- IDLE, exactly one request pending: grant it.
- IDLE, both requests pending: grant the requester that does not match last_grant. After reset the first tie therefore goes to host.
- On grant:
  - latch the channel and the owner;
  - last_grant updates on that same edge;
  - an illegal channel (>MAX_CHAN) goes directly to DONE with rd_err=1 and rd_data=0, and the ADC is never touched;
  - a legal channel goes to SETUP.
- SETUP: adc_chan and adc_batt_sel are driven from the latched channel and held stable until the next grant.
- GO: adc_go=1 for exactly one cycle.
- WAIT:
  - adc_go=0; counter increments every cycle.
  - adc_valid=1: capture adc_in into rd_data, set rd_err=0, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no valid: set rd_data=0 and rd_err=1, increment timeout_cnt (saturates at 255), go to DONE.
  - If valid and terminal count occur in the same cycle, valid wins.
- DONE: the owner's ack is high for one cycle; then return to IDLE.
- Request handling:
  - Requests are sampled only in IDLE.
  - adc_valid is ignored outside WAIT.
  - A requester that drops req mid-operation still receives its ack.
  - A req still high in the IDLE cycle after its ack is treated as a new request.
- Latency, legal channel, grant edge = cycle 0:
  - SETUP is cycle 1, GO is cycle 2, WAIT begins at cycle 3;
  - valid seen in WAIT at cycle k gives ack at cycle k+1;
  - back-to-back minimum is 5 cycles per conversion.
- Latency, illegal channel: ack at cycle 1.

Test Plan:
- Single auto read: auto_chan=5, ADC model returns 0x2A5 three cycles after adc_go → one adc_go pulse with adc_chan=5 and batt_sel=0; auto_ack with rd_data=0x2A5 and rd_err=0; host_ack stays 0.
- Battery channel: host_chan=16, ADC returns 0x3FF → adc_chan=0, adc_batt_sel=1, host_ack with rd_data=0x3FF.
- Contention: auto_req and host_req both held with chans 3 and 7 → grant order host(7), auto(3), host(7), auto(3); last_grant toggles 1,0,1,0; no overlapping adc_go.
- Timeout (TIMEOUT_CYCLES=8), ADC never responds → ack arrives 8 WAIT cycles after GO with rd_err=1 and rd_data=0; timeout_cnt=1. Also drive valid on the terminal cycle → rd_err=0.
- Illegal channel: auto_chan=20 → auto_ack on the cycle after grant with rd_err=1; adc_go never asserted.
- Reset asserted during WAIT, then released with a late adc_valid pulse → all outputs 0, FSM idle, no ack issued.
